// File: rtl/serdes_reset_seq_if.sv
// Control/status bundle between the SERDES reset sequencer and the rPLL/CLKDIV/OSER10 video path.
interface serdes_reset_seq_if;
  logic       pll_lock;
  logic       sw_restart;
  logic       pll_reset;
  logic       clkdiv_resetn;
  logic       oser_reset;
  logic       video_resetn;
  logic       ready;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;

  modport master (
    input  pll_lock, sw_restart,
    output pll_reset, clkdiv_resetn, oser_reset, video_resetn, ready, state, lock_loss_cnt
  );

  modport slave (
    output pll_lock, sw_restart,
    input  pll_reset, clkdiv_resetn, oser_reset, video_resetn, ready, state, lock_loss_cnt
  );
endinterface

// File: rtl/serdes_reset_seq.sv
// DVI/HDMI output-path reset sequencer: PLL -> CLKDIV -> OSER10 -> pixel domain, with lock supervision.
// Optional WAIT_LOCK watchdog is built only when SERDES_SEQ_WATCHDOG_EN is defined.
module serdes_reset_seq #(
  parameter int PLL_RST_CYCLES      = 32,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int DIV_SETTLE_CYCLES   = 16,
  parameter int OSER_HOLD_CYCLES    = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic               clk,
  input  logic               resetn,
  serdes_reset_seq_if.master sif
);

  typedef enum logic [2:0] {
    S_PLL_RST     = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_LOCK_STABLE = 3'd2,
    S_DIV_RST     = 3'd3,
    S_OSER_RST    = 3'd4,
    S_RUN         = 3'd5
  } state_e;

  localparam logic [15:0] PLL_RST_LAST = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] DIV_LAST     = 16'(DIV_SETTLE_CYCLES - 1);
  localparam logic [15:0] OSER_LAST    = 16'(OSER_HOLD_CYCLES - 1);

`ifdef SERDES_SEQ_WATCHDOG_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);
`else
  // Timeout parameter stays in the parameter list so both builds share one instantiation.
  if (LOCK_TIMEOUT_CYCLES > 0) begin : g_no_watchdog
  end
`endif

  logic [1:0]  lock_pipe;
  logic        lock_s;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  loss_q;
  logic        loss_inc;
  logic        pll_reset_q, clkdiv_resetn_q, oser_reset_q, video_resetn_q, ready_q;

  // Lock from a PLL held in reset is meaningless, so the synchronizer is flushed in PLL_RST;
  // the 2-cycle sync latency then applies afresh after every PLL release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 lock_pipe <= '0;
    else if (state_q == S_PLL_RST) lock_pipe <= '0;
    else                         lock_pipe <= {lock_pipe[0], sif.pll_lock};
  end
  assign lock_s = lock_pipe[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_PLL_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    loss_inc = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) state_d = S_LOCK_STABLE;
`ifdef SERDES_SEQ_WATCHDOG_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d  = S_PLL_RST;
          loss_inc = 1'b1;
        end
`endif
      end
      S_LOCK_STABLE: begin
        if (!lock_s)                   state_d = S_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = S_DIV_RST;
      end
      S_DIV_RST: begin
        if (!lock_s) begin
          state_d  = S_PLL_RST;
          loss_inc = 1'b1;
        end else if (cnt_q == DIV_LAST) state_d = S_OSER_RST;
      end
      S_OSER_RST: begin
        if (!lock_s) begin
          state_d  = S_PLL_RST;
          loss_inc = 1'b1;
        end else if (cnt_q == OSER_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d  = S_PLL_RST;
          loss_inc = 1'b1;
        end
      end
      default: state_d = S_PLL_RST;
    endcase
    // Software restart overrides the target but never masks a concurrent loss count.
    if (sif.sw_restart && (state_q != S_PLL_RST)) state_d = S_PLL_RST;
    cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
  end

  // Outputs decode the next state so they move on the same edge as the state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      loss_q          <= '0;
      pll_reset_q     <= 1'b1;
      clkdiv_resetn_q <= 1'b0;
      oser_reset_q    <= 1'b1;
      video_resetn_q  <= 1'b0;
      ready_q         <= 1'b0;
    end else begin
      if (loss_inc && (loss_q != 8'hFF)) loss_q <= loss_q + 8'd1;
      pll_reset_q     <= (state_d == S_PLL_RST);
      clkdiv_resetn_q <= (state_d inside {S_DIV_RST, S_OSER_RST, S_RUN});
      oser_reset_q    <= !(state_d inside {S_OSER_RST, S_RUN});
      video_resetn_q  <= (state_d == S_RUN);
      ready_q         <= (state_d == S_RUN);
    end
  end

  assign sif.pll_reset     = pll_reset_q;
  assign sif.clkdiv_resetn = clkdiv_resetn_q;
  assign sif.oser_reset    = oser_reset_q;
  assign sif.video_resetn  = video_resetn_q;
  assign sif.ready         = ready_q;
  assign sif.state         = state_q;
  assign sif.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_serdes_reset_seq.sv
// Directed bench for serdes_reset_seq: vector table for the cold-start/lock-loss timeline plus corner sequences.
module tb_serdes_reset_seq;
  localparam int PR = 4, LS = 8, DS = 3, OH = 2, TO = 20;

  // {pll_reset, clkdiv_resetn, oser_reset, video_resetn, ready}
  localparam logic [4:0] R_PLL  = 5'b10100;
  localparam logic [4:0] R_WAIT = 5'b00100;
  localparam logic [4:0] R_DIV  = 5'b01100;
  localparam logic [4:0] R_OSER = 5'b01000;
  localparam logic [4:0] R_RUN  = 5'b01011;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  serdes_reset_seq_if sif ();

  serdes_reset_seq #(
    .PLL_RST_CYCLES(PR), .LOCK_STABLE_CYCLES(LS), .DIV_SETTLE_CYCLES(DS),
    .OSER_HOLD_CYCLES(OH), .LOCK_TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .sif(sif)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         adv;
    logic       lock;
    logic [2:0] st;
    logic [4:0] rst;
    logic [7:0] cnt;
    string      name;
  } vec_t;

  function automatic vec_t mk(int adv, logic lock, logic [2:0] st, logic [4:0] rst, logic [7:0] cnt, string name);
    vec_t v;
    v.adv = adv; v.lock = lock; v.st = st; v.rst = rst; v.cnt = cnt; v.name = name;
    return v;
  endfunction

  function automatic logic [15:0] obs();
    return {sif.state, sif.pll_reset, sif.clkdiv_resetn, sif.oser_reset, sif.video_resetn, sif.ready, sif.lock_loss_cnt};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, input string name);
    int n = 0;
    while (sif.state !== s && n < bound) begin
      step(1);
      n++;
    end
    if (sif.state !== s) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for state %0d, state is %0d", name, s, sif.state);
    end
  endtask

  task automatic do_reset(input logic lock);
    resetn = 1'b0;
    sif.pll_lock = lock;
    sif.sw_restart = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[13];
    int   cd_t, os_t, vr_t, rdy_t, n;

    sif.pll_lock = 1'b0;
    sif.sw_restart = 1'b0;

    // Cumulative edge counts after reset release: 0,3,4,6,7,14,15,17,18,19,20,22,23.
    vecs[0]  = mk(0, 1'b1, 3'd0, R_PLL,  8'd0, "reset_values");
    vecs[1]  = mk(3, 1'b1, 3'd0, R_PLL,  8'd0, "pll_rst_hold");
    vecs[2]  = mk(1, 1'b1, 3'd1, R_WAIT, 8'd0, "wait_lock_entry");
    vecs[3]  = mk(2, 1'b1, 3'd1, R_WAIT, 8'd0, "lock_sync_latency");
    vecs[4]  = mk(1, 1'b1, 3'd2, R_WAIT, 8'd0, "lock_stable_entry");
    vecs[5]  = mk(7, 1'b1, 3'd2, R_WAIT, 8'd0, "lock_stable_hold");
    vecs[6]  = mk(1, 1'b1, 3'd3, R_DIV,  8'd0, "div_rst_entry");
    vecs[7]  = mk(2, 1'b1, 3'd3, R_DIV,  8'd0, "div_rst_hold");
    vecs[8]  = mk(1, 1'b1, 3'd4, R_OSER, 8'd0, "oser_rst_entry");
    vecs[9]  = mk(1, 1'b1, 3'd4, R_OSER, 8'd0, "oser_rst_hold");
    vecs[10] = mk(1, 1'b1, 3'd5, R_RUN,  8'd0, "run_at_cycle20");
    vecs[11] = mk(2, 1'b0, 3'd5, R_RUN,  8'd0, "lock_drop_sync_delay");
    vecs[12] = mk(1, 1'b0, 3'd0, R_PLL,  8'd1, "lock_loss_restart");

    do_reset(1'b1);
    foreach (vecs[i]) begin
      sif.pll_lock = vecs[i].lock;
      step(vecs[i].adv);
      check(vecs[i].name, obs(), {vecs[i].st, vecs[i].rst, vecs[i].cnt});
    end

    // sw_restart in RUN: immediate PLL_RST, loss count unchanged.
    sif.pll_lock = 1'b1;
    wait_state(3'd5, 60, "sw_reach_run");
    sif.sw_restart = 1'b1;
    step(1);
    sif.sw_restart = 1'b0;
    check("sw_restart_run", obs(), {3'd0, R_PLL, 8'd1});

    // sw_restart coinciding with lock loss: counter still increments once.
    wait_state(3'd5, 60, "sw_loss_reach_run");
    sif.pll_lock = 1'b0;
    step(2);
    sif.sw_restart = 1'b1;
    step(1);
    sif.sw_restart = 1'b0;
    check("sw_plus_loss", obs(), {3'd0, R_PLL, 8'd2});

    // Saturation of the loss counter over 300 forced losses.
    for (int k = 0; k < 300; k++) begin
      sif.pll_lock = 1'b1;
      wait_state(3'd3, 60, "sat_reach_div");
      sif.pll_lock = 1'b0;
      wait_state(3'd0, 10, "sat_reach_pll_rst");
      if (k == 99) check("loss_cnt_102", sif.lock_loss_cnt, 8'd102);
    end
    check("loss_cnt_saturated", sif.lock_loss_cnt, 8'd255);

    // Release order and ready latency on a fresh cold start.
    do_reset(1'b1);
    cd_t = -1; os_t = -1; vr_t = -1; rdy_t = -1;
    for (int c = 1; c <= 40; c++) begin
      step(1);
      if (cd_t < 0 && sif.clkdiv_resetn === 1'b1) cd_t = c;
      if (os_t < 0 && sif.oser_reset === 1'b0) os_t = c;
      if (vr_t < 0 && sif.video_resetn === 1'b1) vr_t = c;
      if (rdy_t < 0 && sif.ready === 1'b1) rdy_t = c;
    end
    check_rng("ready_latency", rdy_t, 19, 21);
    check("order_div_before_oser", (cd_t > 0) && (cd_t < os_t), 1'b1);
    check("order_oser_before_video", (os_t > 0) && (os_t < vr_t), 1'b1);

    // Asynchronous reset mid-RUN forces reset values without waiting for an edge.
    #3;
    resetn = 1'b0;
    #1;
    check("async_reset_mid_run", obs(), {3'd0, R_PLL, 8'd0});

    // One-cycle lock glitch at stability count 5: back to WAIT_LOCK, no loss, count restarts.
    do_reset(1'b1);
    wait_state(3'd2, 30, "glitch_reach_stable");
    step(5);
    sif.pll_lock = 1'b0;
    step(1);
    sif.pll_lock = 1'b1;
    wait_state(3'd1, 5, "glitch_to_wait_lock");
    check("glitch_no_loss_count", sif.lock_loss_cnt, 8'd0);
    wait_state(3'd2, 5, "glitch_back_stable");
    n = 0;
    while (sif.state === 3'd2 && n < 20) begin
      n++;
      step(1);
    end
    check("stable_restart_len", n, LS);
    check("after_stable_div", sif.state, 3'd3);

    // Lock never arrives.
    do_reset(1'b0);
    wait_state(3'd1, 10, "nolock_reach_wait");
    n = 0;
    while (sif.state === 3'd1 && n < 1000) begin
      n++;
      step(1);
    end
`ifdef SERDES_SEQ_WATCHDOG_EN
    check("watchdog_wait_len", n, TO);
    check("watchdog_state", sif.state, 3'd0);
    check("watchdog_loss_cnt", sif.lock_loss_cnt, 8'd1);
`else
    check("no_watchdog_hold", n, 1000);
    check("no_watchdog_state", sif.state, 3'd1);
    check("no_watchdog_loss_cnt", sif.lock_loss_cnt, 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
